fifo_wr_scheduler: RTL and testbench

FIFO_WR_SCHEDULER -- requirements
Module: fifo_wr_scheduler

---
 rtl/fifo_wr_scheduler_pkg.sv | 15 +
 rtl/fifo_wr_scheduler_if.sv | 30 +++
 rtl/fifo_wr_scheduler_rr_pick.sv | 35 +++
 rtl/fifo_wr_scheduler.sv | 147 ++++++++++++++
 tb/tb_fifo_wr_scheduler.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_wr_scheduler_pkg.sv
// Shared defaults and state encoding for the FIFO write scheduler.
package fifo_sched_pkg;

  localparam int NREQ      = 4;
  localparam int DW        = 8;
  localparam int DEPTH     = 15;
  localparam int MAX_BURST = 4;
  localparam int LVL_W     = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/fifo_wr_scheduler_if.sv
// Requester, consumer and FIFO-side signals of the write scheduler.
interface fifo_wr_scheduler_if #(
  parameter int NREQ = fifo_sched_pkg::NREQ,
  parameter int DW   = fifo_sched_pkg::DW
);

  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    gnt;
  logic               rd_req;
  logic               rd_ack;
  logic               fifo_wr;
  logic [DW-1:0]      fifo_din;
  logic               fifo_rd;
  logic [3:0]         level;
  logic               busy;

  // Environment side: drives requests and observes the scheduler.
  modport master (
    output req, req_data, rd_req,
    input  gnt, rd_ack, fifo_wr, fifo_din, fifo_rd, level, busy
  );

  // Scheduler side.
  modport slave (
    input  req, req_data, rd_req,
    output gnt, rd_ack, fifo_wr, fifo_din, fifo_rd, level, busy
  );

endinterface

// File: rtl/fifo_wr_scheduler_rr_pick.sv
// Combinational round-robin picker: searches from last_owner+1 upward and wraps.
module rr_pick #(
  parameter int NREQ = fifo_sched_pkg::NREQ,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_owner,
  output logic [NREQ-1:0] pick,
  output logic [IW-1:0]   pick_idx,
  output logic            any
);

  logic [IW-1:0] cand_s;
  logic          found_s;

  // First requester after last_owner in circular order wins.
  always_comb begin
    pick     = '0;
    pick_idx = '0;
    found_s  = 1'b0;
    cand_s   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_s = IW'((int'(last_owner) + k) % NREQ);
      if (!found_s && req[cand_s]) begin
        pick[cand_s] = 1'b1;
        pick_idx     = cand_s;
        found_s      = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
    any = found_s;
  end

endmodule

// File: rtl/fifo_wr_scheduler.sv
// Multi-requester FIFO write scheduler with a shadow occupancy count and
// write/read arbitration, so that a write and a read never share a cycle.
module fifo_wr_scheduler #(
  parameter int NREQ      = fifo_sched_pkg::NREQ,
  parameter int DW        = fifo_sched_pkg::DW,
  parameter int DEPTH     = fifo_sched_pkg::DEPTH,
  parameter int MAX_BURST = fifo_sched_pkg::MAX_BURST
) (
  input logic                clk,
  input logic                rst,
  fifo_wr_scheduler_if.slave bus
);

  import fifo_sched_pkg::*;

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);

  state_t            state_r, state_s;
  logic [NREQ-1:0]   gnt_r, gnt_s;
  logic [IW-1:0]     owner_r, owner_s;
  logic [IW-1:0]     last_r, last_s;
  logic [BW-1:0]     burst_r, burst_s;
  logic              tok_wr_r, tok_wr_s;
  logic [LVL_W-1:0]  level_r, level_s;
  logic              fifo_wr_r, fifo_rd_r;
  logic [DW-1:0]     din_r, din_s;
  logic              wr_elig_s, rd_elig_s, wr_acc_s, rd_acc_s;
  logic [NREQ-1:0]   pick_s;
  logic [IW-1:0]     pick_idx_s;
  logic              pick_any_s;
  logic [DW-1:0]     owner_data_s;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_rr_pick (
    .req        (bus.req),
    .last_owner (last_r),
    .pick       (pick_s),
    .pick_idx   (pick_idx_s),
    .any        (pick_any_s)
  );

  assign owner_data_s = bus.req_data[int'(owner_r)*DW +: DW];

  // Write/read eligibility and the alternating tie-break when both contend.
  always_comb begin
    wr_elig_s = (state_r == GRANT) && bus.req[owner_r] && (level_r < LVL_W'(DEPTH));
    rd_elig_s = bus.rd_req && (level_r != {LVL_W{1'b0}});
    wr_acc_s  = wr_elig_s;
    rd_acc_s  = rd_elig_s;
    tok_wr_s  = tok_wr_r;
    if (wr_elig_s && rd_elig_s) begin
      wr_acc_s = tok_wr_r;
      rd_acc_s = !tok_wr_r;
      tok_wr_s = !tok_wr_r;
    end else begin
      tok_wr_s = tok_wr_r;
    end
    if (wr_acc_s) begin
      level_s = level_r + LVL_W'(1);
      din_s   = owner_data_s;
    end else if (rd_acc_s) begin
      level_s = level_r - LVL_W'(1);
      din_s   = din_r;
    end else begin
      level_s = level_r;
      din_s   = din_r;
    end
  end

  // Grant FSM: arbitrate in IDLE, hold the owner in GRANT until drop or burst end.
  always_comb begin
    state_s = state_r;
    gnt_s   = gnt_r;
    owner_s = owner_r;
    last_s  = last_r;
    burst_s = burst_r;
    case (state_r)
      IDLE: begin
        if (pick_any_s) begin
          state_s = GRANT;
          gnt_s   = pick_s;
          owner_s = pick_idx_s;
          last_s  = pick_idx_s;
          burst_s = '0;
        end else begin
          state_s = IDLE;
        end
      end
      GRANT: begin
        if (!bus.req[owner_r]) begin
          state_s = IDLE;
          gnt_s   = '0;
          burst_s = '0;
        end else if (wr_acc_s && (burst_r == BW'(MAX_BURST - 1))) begin
          state_s = IDLE;
          gnt_s   = '0;
          burst_s = '0;
        end else if (wr_acc_s) begin
          burst_s = burst_r + BW'(1);
        end else begin
          burst_s = burst_r;
        end
      end
      default: begin
        state_s = IDLE;
        gnt_s   = '0;
        burst_s = '0;
      end
    endcase
  end

  // State, shadow level and registered FIFO strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      gnt_r     <= '0;
      owner_r   <= '0;
      last_r    <= IW'(NREQ - 1);
      burst_r   <= '0;
      tok_wr_r  <= 1'b1;
      level_r   <= '0;
      fifo_wr_r <= 1'b0;
      fifo_rd_r <= 1'b0;
      din_r     <= '0;
    end else begin
      state_r   <= state_s;
      gnt_r     <= gnt_s;
      owner_r   <= owner_s;
      last_r    <= last_s;
      burst_r   <= burst_s;
      tok_wr_r  <= tok_wr_s;
      level_r   <= level_s;
      fifo_wr_r <= wr_acc_s;
      fifo_rd_r <= rd_acc_s;
      din_r     <= din_s;
    end
  end

  assign bus.gnt      = gnt_r;
  assign bus.fifo_wr  = fifo_wr_r;
  assign bus.fifo_din = din_r;
  assign bus.fifo_rd  = fifo_rd_r;
  assign bus.rd_ack   = fifo_rd_r;
  assign bus.level    = level_r;
  assign bus.busy     = (state_r != IDLE);

endmodule

// File: tb/tb_fifo_wr_scheduler.sv
// Bench for fifo_wr_scheduler: directed vector table, multi-cycle corner
// sequences and randomized traffic against a cycle-level reference model.
module tb_fifo_wr_scheduler;

  localparam int NREQ = 4;
  localparam int MAXB = 4;

  typedef struct {
    int          owner;
    int          last;
    int          burst;
    int          lvl;
    bit          tok;
    bit          wr;
    bit          rd;
    logic [7:0]  din;
    bit          valid;
  } mstate_t;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       rd;
    logic [3:0] e_gnt;
    logic       e_wr;
    logic [7:0] e_din;
    logic       e_rd;
    logic [3:0] e_lvl;
    logic       e_busy;
  } vec_t;

  logic    clk = 1'b0;
  logic    rst = 1'b1;
  int      checks = 0;
  int      errors = 0;
  mstate_t ms = '{default: 0};

  fifo_wr_scheduler_if #(.NREQ(NREQ), .DW(8)) bus_if ();

  fifo_wr_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  // Reference model: one step of the scheduling rules per rising edge.
  function automatic mstate_t model_next(mstate_t s, logic r, logic [3:0] rq,
                                         logic [31:0] rdat, logic rrq);
    mstate_t n;
    bit w_ok, r_ok, do_w, do_r;
    int c;
    n = s;
    if (r) begin
      n = '{default: 0};
      n.owner = -1;
      n.last  = NREQ - 1;
      n.tok   = 1'b1;
      n.valid = 1'b1;
      return n;
    end
    w_ok = (s.owner >= 0) && rq[s.owner[1:0]] && (s.lvl < 15);
    r_ok = rrq && (s.lvl > 0);
    do_w = w_ok;
    do_r = r_ok;
    if (w_ok && r_ok) begin
      do_w  = s.tok;
      do_r  = !s.tok;
      n.tok = !s.tok;
    end
    n.wr = do_w;
    n.rd = do_r;
    if (do_w) n.din = rdat[s.owner*8 +: 8];
    n.lvl = s.lvl + (do_w ? 1 : 0) - (do_r ? 1 : 0);
    if (s.owner < 0) begin
      for (int k = 1; k <= NREQ; k++) begin
        c = (s.last + k) % NREQ;
        if (n.owner < 0 && rq[c[1:0]]) begin
          n.owner = c;
          n.last  = c;
          n.burst = 0;
        end
      end
    end else if (!rq[s.owner[1:0]]) begin
      n.owner = -1;
    end else if (do_w) begin
      n.burst = s.burst + 1;
      if (n.burst == MAXB) begin
        n.owner = -1;
        n.burst = 0;
      end
    end
    n.valid = 1'b1;
    return n;
  endfunction

  // Advance the reference model on every rising edge.
  always @(posedge clk) begin
    ms <= model_next(ms, rst, bus_if.req, bus_if.req_data, bus_if.rd_req);
  end

  function automatic int oh_idx(logic [3:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic check_vec(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Wait for the next falling edge and compare every output with the model.
  task automatic tick();
    logic [3:0] eg;
    @(negedge clk);
    if (ms.valid) begin
      eg = (ms.owner < 0) ? 4'h0 : (4'h1 << ms.owner);
      check_vec("model_ctl",
                {bus_if.gnt, bus_if.fifo_wr, bus_if.fifo_rd, bus_if.rd_ack, bus_if.level, bus_if.busy},
                {eg, ms.wr, ms.rd, ms.rd, 4'(ms.lvl), (ms.owner >= 0)});
      if (ms.wr) check_vec("model_din", bus_if.fifo_din, ms.din);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus_if.req = 4'h0;
    bus_if.rd_req = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  vec_t tbl [14];
  int   order [$];
  int   wc [8];
  int   cur;
  int   nwr;
  int   rd_pct;
  logic [3:0] prev;
  logic [1:0] pat [4];

  initial begin
    bus_if.req      = 4'h0;
    bus_if.rd_req   = 1'b0;
    bus_if.req_data = 32'h4433_2211;

    // rst req rd | gnt wr din rd lvl busy
    tbl[0]  = '{1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0};
    tbl[1]  = '{1'b0, 4'h1, 1'b0, 4'h1, 1'b0, 8'h00, 1'b0, 4'd0, 1'b1};
    tbl[2]  = '{1'b0, 4'h1, 1'b0, 4'h1, 1'b1, 8'h11, 1'b0, 4'd1, 1'b1};
    tbl[3]  = '{1'b0, 4'h1, 1'b0, 4'h1, 1'b1, 8'h11, 1'b0, 4'd2, 1'b1};
    tbl[4]  = '{1'b0, 4'h1, 1'b0, 4'h1, 1'b1, 8'h11, 1'b0, 4'd3, 1'b1};
    tbl[5]  = '{1'b0, 4'h1, 1'b0, 4'h0, 1'b1, 8'h11, 1'b0, 4'd4, 1'b0};
    tbl[6]  = '{1'b0, 4'h1, 1'b0, 4'h1, 1'b0, 8'h11, 1'b0, 4'd4, 1'b1};
    tbl[7]  = '{1'b0, 4'h1, 1'b0, 4'h1, 1'b1, 8'h11, 1'b0, 4'd5, 1'b1};
    tbl[8]  = '{1'b0, 4'h1, 1'b0, 4'h1, 1'b1, 8'h11, 1'b0, 4'd6, 1'b1};
    tbl[9]  = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 8'h11, 1'b0, 4'd6, 1'b0};
    tbl[10] = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 8'h11, 1'b1, 4'd5, 1'b0};
    tbl[11] = '{1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 8'h11, 1'b0, 4'd5, 1'b0};
    tbl[12] = '{1'b1, 4'h0, 1'b1, 4'h0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0};
    tbl[13] = '{1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0};

    @(negedge clk);
    for (int r = 0; r < 14; r++) begin
      rst           = tbl[r].rst;
      bus_if.req    = tbl[r].req;
      bus_if.rd_req = tbl[r].rd;
      tick();
      check_vec($sformatf("tbl_row%0d", r),
                {bus_if.gnt, bus_if.fifo_wr, bus_if.fifo_rd, bus_if.rd_ack, bus_if.level, bus_if.busy},
                {tbl[r].e_gnt, tbl[r].e_wr, tbl[r].e_rd, tbl[r].e_rd, tbl[r].e_lvl, tbl[r].e_busy});
      if (tbl[r].e_wr || tbl[r].rst) check_vec($sformatf("tbl_din%0d", r), bus_if.fifo_din, tbl[r].e_din);
    end

    // Round robin with all requesters held: owners 0,1,2,3,0 with 4 words each.
    do_reset();
    bus_if.req    = 4'hF;
    bus_if.rd_req = 1'b1;
    cur  = -1;
    prev = 4'h0;
    for (int c = 0; c < 80 && order.size() < 6; c++) begin
      tick();
      if (bus_if.gnt != 4'h0 && prev == 4'h0) begin
        cur = oh_idx(bus_if.gnt);
        order.push_back(cur);
      end
      if (bus_if.fifo_wr && cur >= 0) begin
        wc[order.size()-1]++;
        check_vec("rr_din", bus_if.fifo_din, bus_if.req_data[cur*8 +: 8]);
      end
      prev = bus_if.gnt;
    end
    check_vec("rr_grant_count", order.size(), 6);
    for (int g = 0; g < 5; g++) begin
      check_vec($sformatf("rr_owner%0d", g), order[g], g % NREQ);
      check_vec($sformatf("rr_words%0d", g), wc[g], MAXB);
    end

    // Fill to 15, stall requester 2, then one read frees exactly one slot.
    do_reset();
    bus_if.req = 4'h1;
    for (int c = 0; c < 40 && bus_if.level != 4'd15; c++) tick();
    check_vec("fill_level", bus_if.level, 4'd15);
    bus_if.req = 4'h4;
    for (int c = 0; c < 4; c++) begin
      tick();
      check_vec("stall_no_wr", bus_if.fifo_wr, 1'b0);
    end
    check_vec("stall_gnt", bus_if.gnt, 4'h4);
    check_vec("stall_level", bus_if.level, 4'd15);
    bus_if.rd_req = 1'b1;
    tick();
    bus_if.rd_req = 1'b0;
    check_vec("stall_rd", {bus_if.fifo_rd, bus_if.level}, {1'b1, 4'd14});
    tick();
    check_vec("stall_wr", {bus_if.fifo_wr, bus_if.fifo_din, bus_if.level}, {1'b1, 8'h33, 4'd15});
    nwr = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      nwr += int'(bus_if.fifo_wr);
    end
    check_vec("stall_extra_wr", nwr, 0);

    // Contention: strobes alternate write, read, write, read from a fresh token.
    do_reset();
    bus_if.req = 4'h1;
    for (int c = 0; c < 10 && bus_if.level != 4'd1; c++) tick();
    check_vec("cont_level", bus_if.level, 4'd1);
    bus_if.rd_req = 1'b1;
    pat[0] = 2'b10; pat[1] = 2'b01; pat[2] = 2'b10; pat[3] = 2'b01;
    for (int c = 0; c < 4; c++) begin
      tick();
      check_vec($sformatf("cont_strobe%0d", c), {bus_if.fifo_wr, bus_if.fifo_rd}, pat[c]);
    end
    for (int c = 0; c < 4; c++) tick();

    // Reset during the third word of a burst.
    do_reset();
    bus_if.req = 4'h1;
    nwr = 0;
    for (int c = 0; c < 20 && nwr < 3; c++) begin
      tick();
      nwr += int'(bus_if.fifo_wr);
    end
    check_vec("mid_words", nwr, 3);
    rst = 1'b1;
    tick();
    check_vec("mid_reset",
              {bus_if.gnt, bus_if.fifo_wr, bus_if.fifo_rd, bus_if.rd_ack, bus_if.level, bus_if.busy}, 32'h0);
    rst = 1'b0;
    bus_if.req = 4'hF;
    tick();
    check_vec("mid_first_gnt", bus_if.gnt, 4'h1);

    // Randomized traffic against the model, with varying read pressure.
    do_reset();
    rd_pct = 30;
    for (int c = 0; c < 1500; c++) begin
      if (c % 300 == 0) rd_pct = $urandom_range(5, 95);
      if ($urandom_range(0, 3) == 0) bus_if.req = bus_if.req ^ (4'h1 << $urandom_range(0, 3));
      bus_if.rd_req   = ($urandom_range(0, 99) < rd_pct);
      bus_if.req_data = $urandom;
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
